// File: rtl/sdram_pattern_tester.sv
// Burst-mode SDRAM pattern tester: writes five data patterns page by page, reads them back,
// and reports mismatch count plus the first failing word address and read value.
module sdram_pattern_tester #(
  parameter int unsigned SDRAM_ROW_WIDTH_BIT  = 13,
  parameter int unsigned SDRAM_COL_WIDTH_BIT  = 9,
  parameter int unsigned SDRAM_BANK_WIDTH_BIT = 2,
  parameter int unsigned SDRAM_DATA_WIDTH_BIT = 16,
  parameter logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT-1:0] PAGE_LAST = '1
) (
  input  logic                                                            i_clk,
  input  logic                                                            i_rst_n,
  input  logic                                                            i_start,
  input  logic                                                            i_ready,
  output logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT+SDRAM_COL_WIDTH_BIT-1:0] o_ram_addr,
  output logic [SDRAM_COL_WIDTH_BIT:0]                                    o_ram_len,
  output logic                                                            o_ram_write_req,
  output logic                                                            o_ram_read_req,
  input  logic                                                            i_ram_write_valid,
  input  logic                                                            i_ram_read_valid,
  output logic [SDRAM_DATA_WIDTH_BIT-1:0]                                 o_ram_data,
  input  logic [SDRAM_DATA_WIDTH_BIT-1:0]                                 i_ram_data,
  output logic                                                            o_busy,
  output logic                                                            o_done,
  output logic                                                            o_pass,
  output logic [15:0]                                                     o_err_count,
  output logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT+SDRAM_COL_WIDTH_BIT-1:0] o_first_err_addr,
  output logic [SDRAM_DATA_WIDTH_BIT-1:0]                                 o_first_err_data
);

  localparam int unsigned PW = SDRAM_BANK_WIDTH_BIT + SDRAM_ROW_WIDTH_BIT;
  localparam int unsigned CW = SDRAM_COL_WIDTH_BIT;
  localparam int unsigned AW = PW + CW;
  localparam int unsigned DW = SDRAM_DATA_WIDTH_BIT;

  localparam logic [CW:0]   Beats    = {1'b1, {CW{1'b0}}};
  localparam logic [CW:0]   BeatLast = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   BeatOne  = {{CW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PageOne  = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    StIdle, StWaitRdy, StWrReq, StWrBurst, StWrNext,
    StRdReq, StRdBurst, StRdNext, StPatNext, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  page_q, page_d;
  logic [CW:0]    beat_q, beat_d;
  logic [2:0]     pat_q, pat_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic [CW:0]    ram_len_q, ram_len_d;
  logic           wr_req_q, wr_req_d;
  logic           rd_req_q, rd_req_d;
  logic [DW-1:0]  ram_data_q, ram_data_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [15:0]    err_count_q, err_count_d;
  logic [AW-1:0]  first_addr_q, first_addr_d;
  logic [DW-1:0]  first_data_q, first_data_d;

  // Pattern 4 stores each word's own address so address-line faults become visible.
  function automatic logic [DW-1:0] pattern_word(input logic [2:0] pat, input logic [AW-1:0] addr);
    logic [DW-1:0] w;
    w = DW'(addr);
    for (int i = 0; i < DW; i++) begin
      case (pat)
        3'd0:    w[i] = 1'b0;
        3'd1:    w[i] = 1'b1;
        3'd2:    w[i] = i[0];
        3'd3:    w[i] = ~i[0];
        default: w[i] = w[i];
      endcase
    end
    return w;
  endfunction

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    beat_d       = beat_q;
    pat_d        = pat_q;
    ram_addr_d   = ram_addr_q;
    ram_len_d    = ram_len_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    ram_data_d   = ram_data_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    first_addr_d = first_addr_q;
    first_data_d = first_data_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          err_count_d  = '0;
          first_addr_d = '0;
          first_data_d = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          pat_d        = '0;
          page_d       = '0;
          state_d      = StWaitRdy;
        end
      end
      StWaitRdy: if (i_ready) state_d = StWrReq;
      StWrReq: begin
        ram_addr_d = {page_q, {CW{1'b0}}};
        ram_len_d  = Beats;
        wr_req_d   = 1'b1;
        beat_d     = '0;
        ram_data_d = pattern_word(pat_q, {page_q, {CW{1'b0}}});
        state_d    = StWrBurst;
      end
      StWrBurst: begin
        if (i_ram_write_valid) begin
          wr_req_d   = 1'b0;
          beat_d     = beat_q + BeatOne;
          ram_data_d = pattern_word(pat_q, {page_q, beat_d[CW-1:0]});
          if (beat_q == BeatLast) state_d = StWrNext;
        end
      end
      StWrNext: begin
        if (page_q != PAGE_LAST) begin
          page_d  = page_q + PageOne;
          state_d = StWrReq;
        end else begin
          page_d  = '0;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        ram_addr_d = {page_q, {CW{1'b0}}};
        ram_len_d  = Beats;
        rd_req_d   = 1'b1;
        beat_d     = '0;
        state_d    = StRdBurst;
      end
      StRdBurst: begin
        if (i_ram_read_valid) begin
          rd_req_d = 1'b0;
          beat_d   = beat_q + BeatOne;
          if (i_ram_data != pattern_word(pat_q, {page_q, beat_q[CW-1:0]})) begin
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
            // A zero count means no mismatch has been seen yet in this run.
            if (err_count_q == 16'd0) begin
              first_addr_d = {page_q, beat_q[CW-1:0]};
              first_data_d = i_ram_data;
            end
          end
          if (beat_q == BeatLast) state_d = StRdNext;
        end
      end
      StRdNext: begin
        if (page_q != PAGE_LAST) begin
          page_d  = page_q + PageOne;
          state_d = StRdReq;
        end else begin
          page_d  = '0;
          state_d = StPatNext;
        end
      end
      StPatNext: begin
        if (pat_q < 3'd4) begin
          pat_d   = pat_q + 3'd1;
          state_d = StWaitRdy;
        end else begin
          done_d  = 1'b1;
          pass_d  = (err_count_q == 16'd0);
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      page_q       <= '0;
      beat_q       <= '0;
      pat_q        <= '0;
      ram_addr_q   <= '0;
      ram_len_q    <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      ram_data_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      first_addr_q <= '0;
      first_data_q <= '0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      beat_q       <= beat_d;
      pat_q        <= pat_d;
      ram_addr_q   <= ram_addr_d;
      ram_len_q    <= ram_len_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      ram_data_q   <= ram_data_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      first_addr_q <= first_addr_d;
      first_data_q <= first_data_d;
    end
  end

  assign o_ram_addr       = ram_addr_q;
  assign o_ram_len        = ram_len_q;
  assign o_ram_write_req  = wr_req_q;
  assign o_ram_read_req   = rd_req_q;
  assign o_ram_data       = ram_data_q;
  assign o_busy           = (state_q != StIdle) && (state_q != StDone);
  assign o_done           = done_q;
  assign o_pass           = pass_q;
  assign o_err_count      = err_count_q;
  assign o_first_err_addr = first_addr_q;
  assign o_first_err_data = first_data_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: 2 pages x 8 words, behavioural SDRAM controller with
// optional latency, beat gaps, read corruption and stray valid pulses.
module tb_sdram_pattern_tester;

  localparam int CW = 3;
  localparam int PW = 15;
  localparam int AW = PW + CW;
  localparam int DW = 16;
  localparam int NB = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_ready = 1'b0;
  logic [AW-1:0] o_ram_addr;
  logic [CW:0]   o_ram_len;
  logic          o_ram_write_req, o_ram_read_req;
  logic          i_ram_write_valid = 1'b0;
  logic          i_ram_read_valid = 1'b0;
  logic [DW-1:0] o_ram_data;
  logic [DW-1:0] i_ram_data = '0;
  logic          o_busy, o_done, o_pass;
  logic [15:0]   o_err_count;
  logic [AW-1:0] o_first_err_addr;
  logic [DW-1:0] o_first_err_data;

  sdram_pattern_tester #(
    .SDRAM_ROW_WIDTH_BIT (13),
    .SDRAM_COL_WIDTH_BIT (CW),
    .SDRAM_BANK_WIDTH_BIT(2),
    .SDRAM_DATA_WIDTH_BIT(DW),
    .PAGE_LAST           (15'd1)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_start          (i_start),
    .i_ready          (i_ready),
    .o_ram_addr       (o_ram_addr),
    .o_ram_len        (o_ram_len),
    .o_ram_write_req  (o_ram_write_req),
    .o_ram_read_req   (o_ram_read_req),
    .i_ram_write_valid(i_ram_write_valid),
    .i_ram_read_valid (i_ram_read_valid),
    .o_ram_data       (o_ram_data),
    .i_ram_data       (i_ram_data),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_pass           (o_pass),
    .o_err_count      (o_err_count),
    .o_first_err_addr (o_first_err_addr),
    .o_first_err_data (o_first_err_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err = 0;

  // Controller configuration and scoreboard.
  int mode = 0;          // 0 clean, 1 corrupt pat2 addr 13, 2 reads stuck at zero
  int cfg_delay = 0;
  bit cfg_gaps = 1'b0;
  bit cfg_extra = 1'b0;
  bit cfg_ready_rand = 1'b0;
  int burst_no, exp_err, exp_fa, exp_fd, wbad, hold_bad, overlap;
  logic [DW-1:0] mem [0:15];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input int pat, input int addr);
    case (pat)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'hAAAA;
      3:       return 16'h5555;
      default: return addr[15:0];
    endcase
  endfunction

  // Serves one burst; returns early if reset is asserted.
  task automatic serve_burst(input bit is_wr);
    int base, pat, a;
    logic [DW-1:0] rdata;
    base = int'(o_ram_addr);
    pat  = burst_no / 4;
    check_eq("burst_kind", {31'b0, is_wr}, ((burst_no % 4) < 2) ? 32'd1 : 32'd0);
    check_eq("burst_addr", base, (burst_no % 2) * NB);
    check_eq("burst_len", {28'b0, o_ram_len}, NB);
    repeat (cfg_delay) begin
      @(negedge i_clk);
      if (!i_rst_n) return;
      if (!(is_wr ? o_ram_write_req : o_ram_read_req)) hold_bad++;
    end
    for (int n = 0; n < NB; n++) begin
      if (cfg_gaps) begin
        repeat ($urandom_range(2, 0)) begin
          @(negedge i_clk);
          if (!i_rst_n) return;
        end
      end
      if (n == 0 && !(is_wr ? o_ram_write_req : o_ram_read_req)) hold_bad++;
      a = base + n;
      if (is_wr) begin
        if (o_ram_data !== ref_word(pat, a)) wbad++;
        mem[a & 15] = o_ram_data;
        i_ram_write_valid = 1'b1;
      end else begin
        rdata = mem[a & 15];
        if (mode == 1 && pat == 2 && a == 13) rdata = 16'hAAAB;
        if (mode == 2) rdata = 16'h0000;
        if (rdata !== ref_word(pat, a)) begin
          if (exp_err == 0) begin
            exp_fa = a;
            exp_fd = int'(rdata);
          end
          exp_err++;
        end
        i_ram_data = rdata;
        i_ram_read_valid = 1'b1;
      end
      @(negedge i_clk);
      i_ram_write_valid = 1'b0;
      i_ram_read_valid = 1'b0;
      if (!i_rst_n) return;
      if (n == 0 && (o_ram_write_req || o_ram_read_req)) hold_bad++;
    end
    if (cfg_extra) begin
      i_ram_write_valid = is_wr;
      i_ram_read_valid = !is_wr;
      i_ram_data = 16'h1234;
      @(negedge i_clk);
      i_ram_write_valid = 1'b0;
      i_ram_read_valid = 1'b0;
    end
    burst_no++;
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n && (o_ram_write_req || o_ram_read_req)) serve_burst(o_ram_write_req);
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      i_ready = cfg_ready_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (o_ram_write_req && o_ram_read_req) overlap++;
    end
  end

  task automatic clear_score();
    burst_no = 0;
    exp_err  = 0;
    exp_fa   = 0;
    exp_fd   = 0;
    wbad     = 0;
    hold_bad = 0;
    overlap  = 0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic run_test(input bit mid_start);
    int cyc;
    clear_score();
    @(negedge i_clk);
    pulse_start();
    check_eq("busy_after_start", {31'b0, o_busy}, 1);
    check_eq("done_cleared", {31'b0, o_done}, 0);
    if (mid_start) begin
      for (cyc = 0; cyc < 500 && !o_ram_write_req; cyc++) @(negedge i_clk);
      check_eq("wait_wr_req", cyc < 500, 1);
      pulse_start();
    end
    for (cyc = 0; cyc < 20000 && !o_done; cyc++) @(negedge i_clk);
    check_eq("done", {31'b0, o_done}, 1);
    check_eq("busy_at_done", {31'b0, o_busy}, 0);
    check_eq("bursts", burst_no, 20);
    check_eq("write_data", wbad, 0);
    check_eq("req_hold", hold_bad, 0);
    check_eq("req_overlap", overlap, 0);
    check_eq("err_count", {16'b0, o_err_count}, exp_err);
    check_eq("pass", {31'b0, o_pass}, (exp_err == 0) ? 1 : 0);
    check_eq("first_err_addr", o_first_err_addr, exp_fa);
    check_eq("first_err_data", {16'b0, o_first_err_data}, exp_fd);
    repeat (3) @(negedge i_clk);
    check_eq("done_held", {31'b0, o_done}, 1);
    check_eq("idle_after", {31'b0, o_busy}, 0);
  endtask

  initial begin
    int cyc;
    clear_score();
    repeat (3) @(negedge i_clk);
    check_eq("rst_busy", {31'b0, o_busy}, 0);
    check_eq("rst_wr_req", {31'b0, o_ram_write_req}, 0);
    check_eq("rst_rd_req", {31'b0, o_ram_read_req}, 0);
    check_eq("rst_err", {16'b0, o_err_count}, 0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check_eq("idle_no_start", {31'b0, o_busy}, 0);

    // Ideal controller.
    run_test(1'b0);
    // Single corrupted read, random ready.
    mode = 1; cfg_ready_rand = 1'b1;
    run_test(1'b0);
    check_eq("corrupt_count", {16'b0, o_err_count}, 1);
    check_eq("corrupt_addr", o_first_err_addr, 13);
    check_eq("corrupt_data", {16'b0, o_first_err_data}, 32'hAAAB);
    // Reads stuck at zero.
    mode = 2;
    run_test(1'b0);
    check_eq("stuck_count", {16'b0, o_err_count}, 63);
    // Latency and gapped beats.
    mode = 0; cfg_delay = 7; cfg_gaps = 1'b1;
    run_test(1'b0);
    // Stray valids and a start pulse while busy.
    cfg_delay = 0; cfg_gaps = 1'b0; cfg_extra = 1'b1;
    run_test(1'b1);
    cfg_extra = 1'b0;

    // Reset while a read request of pattern 3 is pending.
    cfg_delay = 7; cfg_gaps = 1'b1;
    clear_score();
    @(negedge i_clk);
    pulse_start();
    for (cyc = 0; cyc < 5000 && !(burst_no == 14 && o_ram_read_req); cyc++) @(negedge i_clk);
    check_eq("rst_wait", cyc < 5000, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check_eq("arst_rd_req", {31'b0, o_ram_read_req}, 0);
    check_eq("arst_wr_req", {31'b0, o_ram_write_req}, 0);
    check_eq("arst_addr", o_ram_addr, 0);
    check_eq("arst_len", {28'b0, o_ram_len}, 0);
    check_eq("arst_data", {16'b0, o_ram_data}, 0);
    check_eq("arst_status", {29'b0, o_busy, o_done, o_pass}, 0);
    check_eq("arst_err", {16'b0, o_err_count}, 0);
    check_eq("arst_first", {o_first_err_data, 14'b0, o_first_err_addr[1:0]}, 0);
    check_eq("arst_first_addr", o_first_err_addr, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    check_eq("post_rst_idle", {31'b0, o_busy}, 0);
    run_test(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameter SDRAM_ROW_WIDTH_BIT, default 13, row address width.
REQ-002 Parameter SDRAM_COL_WIDTH_BIT, default 9, column width; page = 2**COL words.
REQ-003 Parameter SDRAM_BANK_WIDTH_BIT, default 2, bank width.
REQ-004 Parameter SDRAM_DATA_WIDTH_BIT, default 16, data word width.
REQ-005 Parameter PAGE_LAST, default all-ones over BANK+ROW bits, index of last {bank,row} page tested.
REQ-006 i_clk  in  1  single clock for all logic, same clock as the controller.
REQ-007 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 i_start  in  1  one-cycle pulse that starts a test run.
REQ-009 i_ready  in  1  controller initialised and idle.
REQ-010 o_ram_addr  out  BANK+ROW+COL  {bank,row,col} burst start address; col always 0.
REQ-011 o_ram_len  out  COL+1  burst length in words; always 2**COL.
REQ-012 o_ram_write_req / o_ram_read_req  out  1 each  burst request to the controller.
REQ-013 i_ram_write_valid / i_ram_read_valid  in  1 each  one beat accepted / delivered per high cycle.
REQ-014 o_ram_data  out  DATA  write word for the current beat.
REQ-015 i_ram_data  in  DATA  read word, qualified by i_ram_read_valid.
REQ-016 o_busy, o_done, o_pass  out  1 each  run status.
REQ-017 o_err_count  out  16  mismatch count, saturating at 16'hFFFF.
REQ-018 o_first_err_addr  out  BANK+ROW+COL  word address of first mismatch.
REQ-019 o_first_err_data  out  DATA  read value of first mismatch.

Function
REQ-020 States SHALL be IDLE, WAIT_RDY, WR_REQ, WR_BURST, WR_NEXT, RD_REQ, RD_BURST, RD_NEXT, PAT_NEXT, DONE.
REQ-021 IDLE: i_start -> WAIT_RDY, clear err_count, first_err regs, o_done, o_pass; pattern index 0; page 0.
REQ-022 WAIT_RDY: stay until i_ready=1, then WR_REQ.
REQ-023 WR_REQ: drive address {page,0}, len 2**COL, assert o_ram_write_req, beat count 0 -> WR_BURST.
REQ-024 Request SHALL stay high until the first valid beat and drop in the cycle after it.
REQ-025 Each i_ram_write_valid cycle: beat count +1, o_ram_data updates next cycle to the next beat's word.
REQ-026 Beat count == 2**COL -> WR_NEXT; page != PAGE_LAST -> page+1, WR_REQ; else page 0, RD_REQ.
REQ-027 RD_REQ/RD_BURST/RD_NEXT SHALL mirror the write phase, using o_ram_read_req and i_ram_read_valid.
REQ-028 Each read beat SHALL compare i_ram_data with expected word for {page,beat}; on mismatch err_count+1 (saturate).
REQ-029 First mismatch of a run SHALL latch o_first_err_addr = {page,beat} and o_first_err_data; later ones leave them unchanged.
REQ-030 Expected/written word per pattern index: 0 -> 16'h0000, 1 -> 16'hFFFF, 2 -> 16'hAAAA, 3 -> 16'h5555, 4 -> low DATA bits of word address {page,beat}.
REQ-031 PAT_NEXT: index < 4 -> index+1, WAIT_RDY; index == 4 -> DONE.
REQ-032 DONE: o_done=1, o_pass=(err_count==0), o_busy=0, -> IDLE in one cycle; o_done/o_pass held until next i_start.
REQ-033 o_busy SHALL be 1 in every state except IDLE and DONE.
REQ-034 i_start while busy SHALL be ignored.
REQ-035 Valid pulses outside the matching burst state, or beyond 2**COL beats, SHALL be ignored.
REQ-036 Write and read requests SHALL never be high in the same cycle.
REQ-037 i_ready low during a burst SHALL NOT abort it; it is sampled only in WAIT_RDY.

Reset
REQ-038 i_rst_n low SHALL immediately force IDLE, all requests 0, o_ram_addr 0, o_ram_len 0, o_ram_data 0, status 0, err_count 0, first_err regs 0.
REQ-039 Reset mid-burst SHALL drop requests asynchronously; after release the block waits for i_start.

Verification
REQ-040 PAGE_LAST=1, COL=3, ideal controller model, i_start -> 5 patterns x 2 pages x 8 beats each direction, o_done=1, o_pass=1, o_err_count=0.
REQ-041 Model corrupts read of page 1 beat 5 in pattern 2 to 16'hAAAB -> o_err_count=1, o_first_err_addr={1,5}, o_first_err_data=16'hAAAB, o_pass=0.
REQ-042 Model stuck data 16'h0000 on all reads -> first error at pattern 1 address 0 data 0, count 4*16-1 (pattern 4 address-0 word matches) =63.
REQ-043 Model delays first valid 7 cycles and gaps beats randomly -> request held until first valid, exactly 8 beats/burst, still pass.
REQ-044 i_rst_n low during RD_BURST of pattern 3 -> o_ram_read_req=0 same cycle, all outputs zero; i_start after release restarts pattern 0, page 0.
REQ-045 i_start pulsed in WR_BURST and extra valid after 8th beat -> both ignored, run completes unchanged.
